// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the requester handshakes (fetch and data side) and the
//            memory-port control/address signals seen by mem_port_arbiter.
//            The bidirectional memory data bus is not part of the bundle. It
//            stays a plain inout on the arbiter so that it resolves as one net
//            in the enclosing level.
// Ports    : none (signal bundle)
//   master - arbiter view: takes requests and memory responses, drives
//            results, strobes and address
//   slave  - environment view: requesters plus memory model
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    // fetch requester
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_done;
    logic                 i_err;
    // data requester
    logic                 d_read;
    logic                 d_write;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_done;
    logic                 d_err;
    // memory port control
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;
    logic                 ackOutput;

    modport master (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata,
        input  inputReady, ackOutput,
        output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
        output readM, writeM, address
    );

    modport slave (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata,
        output inputReady, ackOutput,
        input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
        input  readM, writeM, address
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single external memory port between the instruction
//            fetch unit and the data access unit. The data side has fixed
//            priority. A write wins over a read. Each granted request is
//            latched and its handshake runs to completion, or is aborted with
//            an error pulse when the memory does not answer in time.
// Ports    : clk     - rising-edge clock
//            reset_n - asynchronous active-low reset
//            bus     - requester handshakes and memory control
//                      (mem_port_arbiter_if.master)
//            data    - bidirectional memory data bus. It is driven only
//                      while writeM is high and is high-Z otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    mem_port_arbiter_if.master        bus,
    inout  wire logic [WORD_SIZE-1:0] data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_I_RD = 2'd1;
    localparam logic [1:0] S_D_RD = 2'd2;
    localparam logic [1:0] S_D_WR = 2'd3;

    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    logic [1:0]           state_q,   state_d;
    logic [WORD_SIZE-1:0] addr_q,    addr_d;
    logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
    logic                 readm_q,   readm_d;
    logic                 writem_q,  writem_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 i_done_q,  i_done_d;
    logic                 d_done_q,  d_done_d;
    logic                 i_err_q,   i_err_d;
    logic                 d_err_q,   d_err_d;
    logic [15:0]          wait_cnt_q, wait_cnt_d;

    // A completion pulse is still visible to the requester. Requests are not
    // sampled in that cycle, so a request that is still held is taken up as
    // a new transaction one cycle later.
    logic w_pulse_active;
    assign w_pulse_active = i_done_q | d_done_q | i_err_q | d_err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readm_d    = readm_q;
        writem_d   = writem_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        i_err_d    = 1'b0;
        d_err_d    = 1'b0;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!w_pulse_active) begin
                    if (bus.d_write) begin
                        state_d    = S_D_WR;
                        addr_d     = bus.d_addr;
                        wdata_d    = bus.d_wdata;
                        writem_d   = 1'b1;
                        wait_cnt_d = 16'd0;
                    end else if (bus.d_read) begin
                        state_d    = S_D_RD;
                        addr_d     = bus.d_addr;
                        wdata_d    = bus.d_wdata;
                        readm_d    = 1'b1;
                        wait_cnt_d = 16'd0;
                    end else if (bus.i_req) begin
                        state_d    = S_I_RD;
                        addr_d     = bus.i_addr;
                        wdata_d    = bus.d_wdata;
                        readm_d    = 1'b1;
                        wait_cnt_d = 16'd0;
                    end
                end
            end

            S_I_RD, S_D_RD: begin
                // A response on the same edge as the timeout takes precedence.
                if (bus.inputReady) begin
                    readm_d = 1'b0;
                    state_d = S_IDLE;
                    if (state_q == S_I_RD) begin
                        i_rdata_d = data;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = data;
                        d_done_d  = 1'b1;
                    end
                end else if (wait_cnt_q == C_TIMEOUT) begin
                    readm_d = 1'b0;
                    state_d = S_IDLE;
                    if (state_q == S_I_RD) begin
                        i_err_d = 1'b1;
                    end else begin
                        d_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            S_D_WR: begin
                if (bus.ackOutput) begin
                    writem_d = 1'b0;
                    d_done_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (wait_cnt_q == C_TIMEOUT) begin
                    writem_d = 1'b0;
                    d_err_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                readm_d  = 1'b0;
                writem_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            readm_q    <= 1'b0;
            writem_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readm_q    <= readm_d;
            writem_q   <= writem_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            i_err_q    <= i_err_d;
            d_err_q    <= d_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.readM   = readm_q;
    assign bus.writeM  = writem_q;
    assign bus.address = addr_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.i_err   = i_err_q;
    assign bus.d_err   = d_err_q;

    // The bus is released as soon as writeM drops, including on reset.
    assign data = writem_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
//            The bench itself plays the requesters and the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        mem_drive;
    logic [15:0] mem_val;
    wire  [15:0] data;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE (16),
        .TIMEOUT   (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .data    (data)
    );

    // Memory side of the data bus. During writes it is also used as a probe:
    // it drives 0 and then checks that the arbiter has released the bus.
    assign data = mem_drive ? mem_val : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        mem_drive      = 1'b0;
        mem_val        = 16'h0000;
        bus.i_req      = 1'b0;
        bus.i_addr     = 16'h0000;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = 16'h0000;
        bus.d_wdata    = 16'h0000;
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;
        step();
        step();
        chk("rst_readM",   {15'd0, bus.readM},  16'd0);
        chk("rst_writeM",  {15'd0, bus.writeM}, 16'd0);
        chk("rst_address", bus.address,         16'h0000);
        chk("rst_i_rdata", bus.i_rdata,         16'h0000);
        chk("rst_d_rdata", bus.d_rdata,         16'h0000);
        chk("rst_pulses",  {12'd0, bus.i_done, bus.d_done, bus.i_err, bus.d_err}, 16'd0);
        reset_n = 1'b1;
        step();

        // ---- fetch: response three cycles after the strobe; i_addr changes after grant
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0010;
        step();
        chk("fetch_readM_c1", {15'd0, bus.readM}, 16'd1);
        chk("fetch_addr_c1",  bus.address,        16'h0010);
        bus.i_addr = 16'h0030;
        step();
        chk("fetch_readM_c2", {15'd0, bus.readM}, 16'd1);
        chk("fetch_addr_c2",  bus.address,        16'h0010);
        step();
        chk("fetch_readM_c3", {15'd0, bus.readM}, 16'd1);
        chk("fetch_done_c3",  {15'd0, bus.i_done}, 16'd0);
        bus.inputReady = 1'b1;
        mem_drive      = 1'b1;
        mem_val        = 16'hA5A5;
        step();
        chk("fetch_done",    {15'd0, bus.i_done}, 16'd1);
        chk("fetch_rdata",   bus.i_rdata,         16'hA5A5);
        chk("fetch_readM_0", {15'd0, bus.readM},  16'd0);
        chk("fetch_addr_hold", bus.address,       16'h0010);
        bus.i_req      = 1'b0;
        bus.inputReady = 1'b0;
        mem_drive      = 1'b0;
        step();
        chk("fetch_done_end", {15'd0, bus.i_done}, 16'd0);
        chk("fetch_rdata_hold", bus.i_rdata,       16'hA5A5);

        // ---- write with the ack two cycles after the strobe
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0020;
        bus.d_wdata = 16'h1234;
        step();
        chk("wr_writeM_c1", {15'd0, bus.writeM}, 16'd1);
        chk("wr_addr",      bus.address,         16'h0020);
        chk("wr_bus",       data,                16'h1234);
        step();
        chk("wr_writeM_c2", {15'd0, bus.writeM}, 16'd1);
        chk("wr_done_c2",   {15'd0, bus.d_done}, 16'd0);
        bus.ackOutput = 1'b1;
        step();
        chk("wr_done",      {15'd0, bus.d_done}, 16'd1);
        chk("wr_writeM_0",  {15'd0, bus.writeM}, 16'd0);
        bus.d_write   = 1'b0;
        bus.ackOutput = 1'b0;
        mem_drive     = 1'b1;
        mem_val       = 16'h0000;
        #1;
        chk("wr_bus_released", data, 16'h0000);
        mem_drive = 1'b0;
        step();
        chk("wr_done_end", {15'd0, bus.d_done}, 16'd0);

        // ---- contention: fetch and data read raised in the same cycle
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0040;
        bus.d_read = 1'b1;
        bus.d_addr = 16'h0050;
        step();
        chk("cont_d_first_readM", {15'd0, bus.readM}, 16'd1);
        chk("cont_d_first_addr",  bus.address,        16'h0050);
        bus.inputReady = 1'b1;
        mem_drive      = 1'b1;
        mem_val        = 16'hBEEF;
        step();
        chk("cont_d_done",  {15'd0, bus.d_done}, 16'd1);
        chk("cont_d_rdata", bus.d_rdata,         16'hBEEF);
        chk("cont_i_done0", {15'd0, bus.i_done}, 16'd0);
        chk("cont_readM_0", {15'd0, bus.readM},  16'd0);
        bus.d_read     = 1'b0;
        bus.inputReady = 1'b0;
        mem_drive      = 1'b0;
        step();
        chk("cont_gap_readM", {15'd0, bus.readM},  16'd0);
        chk("cont_gap_done",  {15'd0, bus.d_done}, 16'd0);
        step();
        chk("cont_i_readM", {15'd0, bus.readM}, 16'd1);
        chk("cont_i_addr",  bus.address,        16'h0040);
        bus.inputReady = 1'b1;
        mem_drive      = 1'b1;
        mem_val        = 16'h0F0F;
        step();
        chk("cont_i_done",    {15'd0, bus.i_done}, 16'd1);
        chk("cont_i_rdata",   bus.i_rdata,         16'h0F0F);
        chk("cont_d_rdata_h", bus.d_rdata,         16'hBEEF);
        bus.i_req      = 1'b0;
        bus.inputReady = 1'b0;
        mem_drive      = 1'b0;
        step();

        // ---- timeout: no response, readM high for TIMEOUT+1 = 5 cycles
        bus.d_read = 1'b1;
        bus.d_addr = 16'h0060;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("to_readM_c%0d", k), {15'd0, bus.readM}, 16'd1);
            chk($sformatf("to_err_c%0d", k),   {15'd0, bus.d_err}, 16'd0);
        end
        step();
        chk("to_err",       {15'd0, bus.d_err},  16'd1);
        chk("to_no_done",   {15'd0, bus.d_done}, 16'd0);
        chk("to_readM_0",   {15'd0, bus.readM},  16'd0);
        chk("to_rdata_keep", bus.d_rdata,        16'hBEEF);
        bus.d_read = 1'b0;
        step();
        chk("to_err_end", {15'd0, bus.d_err}, 16'd0);

        // ---- responses in IDLE are ignored
        bus.inputReady = 1'b1;
        bus.ackOutput  = 1'b1;
        step();
        chk("idle_resp_pulses", {12'd0, bus.i_done, bus.d_done, bus.i_err, bus.d_err}, 16'd0);
        chk("idle_resp_strobe", {14'd0, bus.readM, bus.writeM}, 16'd0);
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;

        // ---- read and write together: the write wins
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0070;
        bus.d_wdata = 16'hCAFE;
        step();
        chk("rw_strobes", {14'd0, bus.readM, bus.writeM}, 16'd1);
        chk("rw_bus",     data,                           16'hCAFE);
        bus.ackOutput = 1'b1;
        step();
        chk("rw_done", {15'd0, bus.d_done}, 16'd1);
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.ackOutput = 1'b0;
        step();

        // ---- response on the timeout edge: the response wins
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0080;
        for (int k = 0; k < 5; k++) step();
        chk("edge_readM", {15'd0, bus.readM}, 16'd1);
        bus.inputReady = 1'b1;
        mem_drive      = 1'b1;
        mem_val        = 16'h1111;
        step();
        chk("edge_done",  {15'd0, bus.i_done}, 16'd1);
        chk("edge_noerr", {15'd0, bus.i_err},  16'd0);
        chk("edge_rdata", bus.i_rdata,         16'h1111);
        bus.i_req      = 1'b0;
        bus.inputReady = 1'b0;
        mem_drive      = 1'b0;
        step();

        // ---- asynchronous reset in the middle of a write
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0090;
        bus.d_wdata = 16'h7777;
        step();
        chk("rstw_writeM_1", {15'd0, bus.writeM}, 16'd1);
        reset_n   = 1'b0;
        mem_drive = 1'b1;
        mem_val   = 16'h0000;
        #1;
        chk("rstw_writeM_0", {15'd0, bus.writeM}, 16'd0);
        chk("rstw_bus_rel",  data,                16'h0000);
        chk("rstw_no_done",  {15'd0, bus.d_done}, 16'd0);
        mem_drive   = 1'b0;
        bus.d_write = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("rstw_address", bus.address, 16'h0000);
        chk("rstw_i_rdata", bus.i_rdata, 16'h0000);
        chk("rstw_d_rdata", bus.d_rdata, 16'h0000);
        chk("rstw_outputs", {10'd0, bus.readM, bus.writeM, bus.i_done, bus.d_done, bus.i_err, bus.d_err}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single external memory port (address, bidirectional data bus, readM/writeM, inputReady/ackOutput) between the instruction-fetch unit and the data-access unit of the 16-bit CPU. Latches each granted request, runs the read or write handshake to completion, returns read data and a one-cycle done pulse to the owner, and aborts with an error pulse on a memory timeout. Sits between the core's fetch/data-memory logic and the memory model.

## Interface
- WORD_SIZE, 16, address and data width
- TIMEOUT, 255, max cycles to wait for inputReady/ackOutput before abort (1..65535)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch read request, held until i_done/i_err
- i_addr  input  WORD_SIZE  fetch address
- i_rdata  output  WORD_SIZE  fetched word, valid while i_done=1
- i_done  output  1  one-cycle fetch completion pulse
- d_read  input  1  data read request, held until d_done/d_err
- d_write  input  1  data write request, held until d_done/d_err
- d_addr  input  WORD_SIZE  data address
- d_wdata  input  WORD_SIZE  write data
- d_rdata  output  WORD_SIZE  read word, valid while d_done=1
- d_done  output  1  one-cycle data completion pulse
- i_err, d_err  output  1 each  one-cycle timeout pulse (replaces done)
- readM  output  1  memory read strobe
- writeM  output  1  memory write strobe
- address  output  WORD_SIZE  memory address
- data  inout  WORD_SIZE  memory data bus; driven only while writeM=1, else high-Z
- inputReady  input  1  memory read data valid
- ackOutput  input  1  memory write accepted

## Operation
- States: IDLE, I_RD, D_RD, D_WR. All outputs registered.
- IDLE grant (evaluated at clock edge, only if i_done, d_done, i_err, d_err all 0): d_write -> D_WR; else d_read -> D_RD; else i_req -> I_RD; else stay. Data side has fixed priority over fetch. d_read and d_write both high: write wins.
- On grant: latch address (d_addr or i_addr) and d_wdata; assert readM (I_RD, D_RD) or writeM (D_WR); clear wait counter. Requester input changes after grant are ignored.
- I_RD/D_RD: at edge with inputReady=1: capture data into i_rdata/d_rdata, readM<=0, pulse matching done, -> IDLE.
- D_WR: at edge with ackOutput=1: writeM<=0 (bus released), pulse d_done, -> IDLE.
- Wait counter (16-bit) increments each cycle in a busy state without response; when it reaches TIMEOUT: drop strobe, pulse i_err or d_err (no done), rdata unchanged, -> IDLE.
- Response and timeout on same edge: response wins.
- inputReady/ackOutput in IDLE: ignored.
- i_rdata/d_rdata hold last captured value until next capture.
- Requester must deassert or change its request in the cycle its done/err is high; arbiter never samples requests in that cycle, so a held request is re-issued as a new transaction one cycle later.

## Timing
- Async reset (reset_n=0): state IDLE; readM, writeM, all done/err 0; address, i_rdata, d_rdata, wait counter 0; data high-Z. Takes effect immediately, aborting any transaction without done/err.
- Request high before edge N (IDLE) -> strobe and address valid after edge N.
- Response sampled at edge N+k (k>=1) -> strobe low and done high after N+k; done low after N+k+1.
- Minimum transaction: 2 cycles strobe-to-done plus 1 gap cycle; back-to-back throughput one access per 3 cycles with single-cycle memory.
- Timeout: err asserted after edge where counter = TIMEOUT, i.e. TIMEOUT+1 cycles after strobe rises.
- Fetch can wait indefinitely only if data requests are issued continuously; core guarantees at most one data access per instruction.

## Test plan
- Reset: reset_n=0 mid-D_WR with writeM=1 -> writeM=0, data=Z, no d_done; after release, IDLE with all outputs 0.
- Fetch: i_req, i_addr=0x0010, memory returns 0xA5A5 with inputReady 3 cycles later -> readM high 3 cycles, address=0x0010, i_done one cycle with i_rdata=0xA5A5.
- Write: d_write, d_addr=0x0020, d_wdata=0x1234, ackOutput after 2 cycles -> data bus=0x1234 only while writeM=1, d_done one pulse, bus Z afterwards.
- Contention: i_req and d_read rise same cycle -> D_RD served first, d_done; I_RD granted one cycle after d_done; i_done follows; no overlap of strobes.
- Timeout: TIMEOUT=4, d_read, memory never responds -> readM high 5 cycles, d_err pulse, no d_done, d_rdata unchanged.
- Request change mid-transaction: i_addr changes 0x0010->0x0030 after grant -> address stays 0x0010 until i_done.
